// File: rtl/multi_debounce.sv
// Multi-channel switch debouncer: 2-flop synchroniser, per-channel stability counter, rise/fall strobes.
// Optional push-on/push-off TOGGLE outputs when MULTI_DEBOUNCE_TOGGLE_EN is defined.
module multi_debounce #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic                CLKIN,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] SW_IN,
  output logic [CHANNELS-1:0] DB_OUT,
  output logic [CHANNELS-1:0] RISE,
  output logic [CHANNELS-1:0] FALL,
  output logic                ANY_EDGE
`ifdef MULTI_DEBOUNCE_TOGGLE_EN
  ,
  output logic [CHANNELS-1:0] TOGGLE
`endif
);

  generate
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
      $error("multi_debounce: CHANNELS must be in 1..32");
    end
    if (STABLE_CYCLES < 1 ||
        64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_stable
      $error("multi_debounce: STABLE_CYCLES must be in 1..2^CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0]    LAST     = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] lvl;
  logic [CNT_W-1:0]    cnt   [CHANNELS];
  logic [CNT_W-1:0]    cnt_n [CHANNELS];
  logic [CHANNELS-1:0] db_n;
  logic [CHANNELS-1:0] rise_n;
  logic [CHANNELS-1:0] fall_n;

  assign lvl = s2 ^ INACTIVE;

  always_comb begin
    db_n   = DB_OUT;
    rise_n = '0;
    fall_n = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_n[i] = '0;
      // Counter only runs while the level disagrees; it stops at LAST, so it never wraps.
      if (lvl[i] != DB_OUT[i]) begin
        if (cnt[i] == LAST) begin
          db_n[i]   = lvl[i];
          rise_n[i] = lvl[i];
          fall_n[i] = ~lvl[i];
        end else begin
          cnt_n[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      s1       <= INACTIVE;
      s2       <= INACTIVE;
      cnt      <= '{default: '0};
      DB_OUT   <= '0;
      RISE     <= '0;
      FALL     <= '0;
      ANY_EDGE <= 1'b0;
`ifdef MULTI_DEBOUNCE_TOGGLE_EN
      TOGGLE   <= '0;
`endif
    end else begin
      s1       <= SW_IN;
      s2       <= s1;
      cnt      <= cnt_n;
      DB_OUT   <= db_n;
      RISE     <= rise_n;
      FALL     <= fall_n;
      ANY_EDGE <= |(rise_n | fall_n);
`ifdef MULTI_DEBOUNCE_TOGGLE_EN
      TOGGLE   <= TOGGLE ^ rise_n;
`endif
    end
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed self-checking bench for multi_debounce (4 channels, STABLE_CYCLES=4, active-low pins).
module tb_multi_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'b1111;
  logic [3:0] db, rise, fall;
  logic       any;
`ifdef MULTI_DEBOUNCE_TOGGLE_EN
  logic [3:0] tog;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multi_debounce #(
    .CHANNELS(4),
    .CNT_W(8),
    .STABLE_CYCLES(4),
    .ACTIVE_LOW(1)
  ) dut (
    .CLKIN(clk),
    .RESET(rst),
    .SW_IN(sw),
    .DB_OUT(db),
    .RISE(rise),
    .FALL(fall),
    .ANY_EDGE(any)
`ifdef MULTI_DEBOUNCE_TOGGLE_EN
    ,
    .TOGGLE(tog)
`endif
  );

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sw  = 4'b1111;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if ({db, rise, fall, any} !== 13'b0) $display("FAIL reset_outputs: got db=%b rise=%b fall=%b any=%b, expected all 0", db, rise, fall, any); else passed++;
`ifdef MULTI_DEBOUNCE_TOGGLE_EN
    total++; if (tog !== 4'b0000) $display("FAIL reset_toggle: got %b, expected 0000", tog); else passed++;
`endif
    for (int k = 0; k < 3; k++) tick();
    total++; if ({db, rise, fall, any} !== 13'b0) $display("FAIL idle_after_reset: got db=%b rise=%b fall=%b any=%b, expected all 0", db, rise, fall, any); else passed++;
  endtask

  task automatic test_clean_press();
    sw[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++; if (db !== 4'b0000 || rise !== 4'b0000) $display("FAIL press_early edge%0d: got db=%b rise=%b, expected 0000/0000", k, db, rise); else passed++;
    end
    tick();
    total++; if (db !== 4'b0001) $display("FAIL press_db: got %b, expected 0001", db); else passed++;
    total++; if (rise !== 4'b0001 || fall !== 4'b0000 || any !== 1'b1) $display("FAIL press_strobe: got rise=%b fall=%b any=%b, expected 0001/0000/1", rise, fall, any); else passed++;
    tick();
    total++; if (rise !== 4'b0000 || any !== 1'b0 || db !== 4'b0001) $display("FAIL press_strobe_end: got rise=%b any=%b db=%b, expected 0000/0/0001", rise, any, db); else passed++;
  endtask

  task automatic test_bounce();
    int bad = 0;
    for (int seg = 0; seg < 6; seg++) begin
      sw[1] = seg[0];
      for (int k = 0; k < 2; k++) begin
        tick();
        if (db !== 4'b0001 || rise !== 4'b0000 || fall !== 4'b0000 || any !== 1'b0) bad++;
      end
    end
    sw[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (db !== 4'b0001 || rise !== 4'b0000 || fall !== 4'b0000 || any !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL bounce_reject: %0d bad cycles seen, expected 0 (last db=%b rise=%b)", bad, db, rise); else passed++;
    sw[1] = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    total++; if (db !== 4'b0001) $display("FAIL bounce_hold_early: got db=%b, expected 0001", db); else passed++;
    tick();
    total++; if (db !== 4'b0011 || rise !== 4'b0010) $display("FAIL bounce_hold_rise: got db=%b rise=%b, expected 0011/0010", db, rise); else passed++;
  endtask

  task automatic test_release_simultaneous();
    sw[1] = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    total++; if (db !== 4'b0001 || fall !== 4'b0010 || rise !== 4'b0000) $display("FAIL release_ch1: got db=%b fall=%b rise=%b, expected 0001/0010/0000", db, fall, rise); else passed++;
    sw[2] = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    total++; if (db !== 4'b0101 || rise !== 4'b0100) $display("FAIL press_ch2: got db=%b rise=%b, expected 0101/0100", db, rise); else passed++;
    tick();
    sw[0] = 1'b1;
    sw[2] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    total++; if (db !== 4'b0101 || fall !== 4'b0000 || any !== 1'b0) $display("FAIL simul_early: got db=%b fall=%b any=%b, expected 0101/0000/0", db, fall, any); else passed++;
    tick();
    total++; if (db !== 4'b0000 || fall !== 4'b0101 || rise !== 4'b0000 || any !== 1'b1) $display("FAIL simul_fall: got db=%b fall=%b rise=%b any=%b, expected 0000/0101/0000/1", db, fall, rise, any); else passed++;
    tick();
    total++; if (fall !== 4'b0000 || any !== 1'b0) $display("FAIL simul_pulse_end: got fall=%b any=%b, expected 0000/0", fall, any); else passed++;
  endtask

  task automatic test_reset_midcount();
    sw[3] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    total++; if (db !== 4'b0000 || rise !== 4'b0000) $display("FAIL midreset_hold: got db=%b rise=%b, expected 0000/0000", db, rise); else passed++;
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++; if (db !== 4'b0000 || rise !== 4'b0000) $display("FAIL midreset_early edge%0d: got db=%b rise=%b, expected 0000/0000", k, db, rise); else passed++;
    end
    tick();
    total++; if (db !== 4'b1000 || rise !== 4'b1000 || any !== 1'b1) $display("FAIL midreset_rise: got db=%b rise=%b any=%b, expected 1000/1000/1", db, rise, any); else passed++;
  endtask

`ifdef MULTI_DEBOUNCE_TOGGLE_EN
  task automatic test_toggle();
    logic exp_t = 1'b0;
    for (int p = 0; p < 3; p++) begin
      sw[2] = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      total++; if (tog[2] !== exp_t) $display("FAIL toggle_before_rise%0d: got %b, expected %b", p, tog[2], exp_t); else passed++;
      tick();
      exp_t = ~exp_t;
      total++; if (tog[2] !== exp_t || rise[2] !== 1'b1) $display("FAIL toggle_on_rise%0d: got tog=%b rise=%b, expected %b/1", p, tog[2], rise[2], exp_t); else passed++;
      sw[2] = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      total++; if (tog[2] !== exp_t || fall[2] !== 1'b1) $display("FAIL toggle_on_fall%0d: got tog=%b fall=%b, expected %b/1", p, tog[2], fall[2], exp_t); else passed++;
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_simultaneous();
    test_reset_midcount();
`ifdef MULTI_DEBOUNCE_TOGGLE_EN
    test_toggle();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multi_debounce.md
Name: multi_debounce

Overview:
- Parametrised, clocked successor to the single-channel SR-latch bounceless switch.
- Debounces CHANNELS independent mechanical switch inputs (lab DIP/pushbuttons) with a synchroniser and a per-channel stability counter.
- Per channel, emits a clean level plus single-cycle rise/fall strobes for downstream counters and FSMs in later labs.
- Works with single-throw switches; no NC/NO pair is required.

Parameters:
- CHANNELS, 4, number of independent switch channels (1..32).
- CNT_W, 16, width of each per-channel stability counter.
- STABLE_CYCLES, 50000, consecutive clock cycles the synchronised input must differ from DB_OUT before DB_OUT updates. Legal range 1..2^CNT_W-1; out of range is a compile-time error.
- ACTIVE_LOW, 1, if 1 the raw inputs are inverted after synchronisation (pressed = 0 on pin).

Ports:
- CLKIN  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLKIN.
- SW_IN  input  CHANNELS  raw asynchronous switch pins.
- DB_OUT  output  CHANNELS  debounced level per channel (1 = pressed).
- RISE  output  CHANNELS  one-cycle strobe when DB_OUT[i] goes 0->1.
- FALL  output  CHANNELS  one-cycle strobe when DB_OUT[i] goes 1->0.
- ANY_EDGE  output  1  OR of all RISE and FALL bits, registered in the same cycle as the strobes.
- TOGGLE  output  CHANNELS  present only with TOGGLE_EN.

Behaviour:
- Reset (RESET=1 at a rising edge):
  - Synchroniser stages load the inactive pin level (1 if ACTIVE_LOW, else 0).
  - Counters, DB_OUT, RISE, FALL, ANY_EDGE and TOGGLE all go to 0.
  - Reset overrides all other activity and may be applied mid-count; the count is discarded.
- Synchroniser: two flops per channel (s1 <- SW_IN, s2 <- s1). Then lvl[i] = s2[i] XOR ACTIVE_LOW.
- Per-channel counter, evaluated each edge when not in reset:
  - lvl[i] == DB_OUT[i]: counter <= 0.
  - lvl[i] != DB_OUT[i] and counter == STABLE_CYCLES-1: DB_OUT[i] <= lvl[i]; counter <= 0; RISE[i] or FALL[i] <= 1 for exactly that next cycle.
  - Otherwise: counter <= counter+1.
- Glitch rejection: any bounce that returns lvl to DB_OUT before STABLE_CYCLES consecutive differing edges clears the counter; no output change and no strobe.
- Latency: for an input held steady after a change, DB_OUT updates on the (2+STABLE_CYCLES)-th rising edge after the change. The strobe is visible in the cycle immediately after that edge and deasserts on the next edge.
- RISE and FALL for the same channel are never both 1. Strobes are registered (no combinational path from SW_IN).
- Channels are fully independent. Simultaneous qualifying changes on several channels all strobe in the same cycle; ANY_EDGE = 1 for that one cycle.
- Counter never wraps: maximum value reached is STABLE_CYCLES-1.
- STABLE_CYCLES = 1: DB_OUT follows lvl with one extra edge of delay, and a strobe accompanies every change.

Optional Feature:
- Macro: MULTI_DEBOUNCE_TOGGLE_EN.
- Defined:
  - TOGGLE port exists.
  - TOGGLE[i] inverts on every RISE[i], on the same edge the strobe is registered.
  - Resets to 0.
  - Gives push-on/push-off behaviour per channel.
- Undefined: TOGGLE port and its flops are absent; all other behaviour is identical.

Test Plan:
- Reset check: CHANNELS=4, STABLE_CYCLES=4, ACTIVE_LOW=1, SW_IN=4'b1111, RESET high 2 cycles -> DB_OUT=0, RISE=FALL=0, ANY_EDGE=0, TOGGLE=0.
- Clean press: SW_IN[0] driven 1->0 and held -> DB_OUT[0]=1 after the 6th rising edge; RISE[0]=1 for exactly one cycle; ANY_EDGE=1 that cycle; other channels unchanged.
- Bounce rejection: SW_IN[1] toggles 0/1/0/1 every 2 cycles for 12 cycles, then returns to 1 -> DB_OUT[1] stays 0; no strobes. Then held 0 -> RISE[1] 6 edges after the last transition.
- Release and simultaneity:
  - Channels 0 and 2 pressed (DB_OUT=4'b0101), then both released on the same cycle -> FALL=4'b0101 in one cycle, DB_OUT=0, single ANY_EDGE pulse.
  - Channel 3 pressed while RESET is asserted at count 2 -> counter cleared; no strobe until 6 edges after RESET deasserts.
- Toggle (macro defined): three clean presses/releases of channel 2 -> TOGGLE[2] sequence 1,0,1, changing only on RISE[2].
